// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// slave = controller side, master = datapath side.
interface multicycle_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUControl;
  logic [3:0]  State;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
    input  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
    output ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: Moore FSM plus instruction decode.
// Define COND_EXEC_EN to enable the NZCV flag register and conditional execution.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC+4
// DECODE   | read registers, pick execution path
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write loaded data to register file
// MEMWRITE | write data memory
// EXECR    | ALU op, register operand
// EXECI    | ALU op, immediate operand
// ALUWB    | write ALU result to register file
// BRANCH   | PC <= branch target
module multicycle_controller #(
  parameter logic [3:0] NZCV_RST = 4'b0000
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t      state_q;
  state_t      state_d;
  state_t      out_state;

  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        cond_ex;
  logic [1:0]  dp_ctl;
  logic        dp_valid;

  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic        adr_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [1:0]  alu_control;

  assign cond  = bus.Instr[19:16];
  assign op    = bus.Instr[15:14];
  assign funct = bus.Instr[13:8];
  assign rd    = bus.Instr[3:0];

`ifdef COND_EXEC_EN
  logic [3:0] flags_q;
  logic       n_f, z_f, c_f, v_f;
  logic       flag_load;
  logic       unused_instr;

  assign {n_f, z_f, c_f, v_f} = flags_q;
  assign unused_instr = ^bus.Instr[7:4];

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // S bit set and condition passed: capture the flags produced in the execute cycle
  assign flag_load = rst && (state_q == S_EXECR || state_q == S_EXECI)
                     && funct[0] && cond_ex;

  always_ff @(posedge clk) begin
    if (!rst)
      flags_q <= NZCV_RST;
    else if (flag_load)
      flags_q <= bus.ALUFlags;
  end
`else
  logic unused_cfg;

  assign cond_ex    = 1'b1;
  assign unused_cfg = ^{bus.Instr[7:4], cond, bus.ALUFlags, NZCV_RST};
`endif

  always_comb begin
    dp_ctl   = 2'b00;
    dp_valid = 1'b1;
    case (funct[4:1])
      4'b0100: dp_ctl = 2'b00;
      4'b0010: dp_ctl = 2'b01;
      4'b0000: dp_ctl = 2'b10;
      4'b1100: dp_ctl = 2'b11;
      default: begin
        dp_ctl   = 2'b00;
        dp_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;

    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase

    // While in reset the outputs show FETCH decode with its writes masked below
    out_state = rst ? state_q : S_FETCH;

    case (out_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR:   alu_src_b = 2'b01;
      S_MEMREAD:  adr_src   = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_ex;
        pc_write   = cond_ex & (rd == 4'hF);
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = cond_ex;
      end
      S_EXECR:    alu_control = dp_ctl;
      S_EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = dp_ctl;
      end
      S_ALUWB: begin
        reg_write = cond_ex & dp_valid;
        pc_write  = cond_ex & dp_valid & (rd == 4'hF);
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex;
      end
      default: ;
    endcase

    if (!rst) begin
      pc_write = 1'b0;
      ir_write = 1'b0;
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01) && !funct[0], op == 2'b10};
  assign bus.State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_multicycle_controller;

`ifdef COND_EXEC_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller #(.NZCV_RST(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    logic [3:0]  st;
    logic [15:0] ctl;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  initial begin : monitor
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
               bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.RegSrc,
               bus.ALUControl};
        checks++;
        if (bus.State !== e.st || act !== e.ctl) begin
          errors++;
          $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                   e.nm, bus.State, act, e.st, e.ctl);
        end
      end
    end
  end

  // ctl order: PCWrite IRWrite RegWrite MemWrite AdrSrc ALUSrcA ALUSrcB ResultSrc ImmSrc RegSrc ALUControl
  task automatic cyc(input string nm, input logic [3:0] st,
                     input bit pcw, input bit irw, input bit rw, input bit mw,
                     input bit adr, input bit srca, input logic [1:0] srcb,
                     input logic [1:0] res, input logic [1:0] imm,
                     input logic [1:0] rs, input logic [1:0] aluc);
    exp_t e;
    e.nm  = nm;
    e.st  = st;
    e.ctl = {pcw, irw, rw, mw, adr, srca, srcb, res, imm, rs, aluc};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [19:0] instr, input logic [3:0] flags);
    bus.Instr    = instr;
    bus.ALUFlags = flags;
  endtask

  task automatic fetch(input string nm, input logic [1:0] imm, input logic [1:0] rs);
    cyc(nm, 4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, imm, rs, 2'b00);
  endtask

  task automatic decode(input string nm, input logic [1:0] imm, input logic [1:0] rs);
    cyc(nm, 4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, imm, rs, 2'b00);
  endtask

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: got no end of stimulus, expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : stim
    issue(20'hE2821, 4'b0000);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_hold", 4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    rst = 1'b1;

    // ADD R1,R2,#5
    fetch("add_fetch", 2'b00, 2'b00);
    decode("add_decode", 2'b00, 2'b00);
    cyc("add_execi", 4'd7, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("add_aluwb", 4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // LDR
    issue(20'hE5903, 4'b0000);
    fetch("ldr_fetch", 2'b01, 2'b00);
    decode("ldr_decode", 2'b01, 2'b00);
    cyc("ldr_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc("ldr_memread", 4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc("ldr_memwb", 4'd4, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);

    // STR
    issue(20'hE5803, 4'b0000);
    fetch("str_fetch", 2'b01, 2'b10);
    decode("str_decode", 2'b01, 2'b10);
    cyc("str_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00);
    cyc("str_memwrite", 4'd5, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);

    // AND R2 (register operand)
    issue(20'hE0002, 4'b0000);
    fetch("and_fetch", 2'b00, 2'b00);
    decode("and_decode", 2'b00, 2'b00);
    cyc("and_execr", 4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    cyc("and_aluwb", 4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // ORR R2
    issue(20'hE1802, 4'b0000);
    fetch("orr_fetch", 2'b00, 2'b00);
    decode("orr_decode", 2'b00, 2'b00);
    cyc("orr_execr", 4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11);
    cyc("orr_aluwb", 4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Unsupported funct: ALU add, RegWrite suppressed
    issue(20'hE2E21, 4'b0000);
    fetch("bad_fetch", 2'b00, 2'b00);
    decode("bad_decode", 2'b00, 2'b00);
    cyc("bad_execi", 4'd7, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("bad_aluwb", 4'd8, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // SUBS producing Z=1, then BEQ taken
    issue(20'hE2500, 4'b0100);
    fetch("subs1_fetch", 2'b00, 2'b00);
    decode("subs1_decode", 2'b00, 2'b00);
    cyc("subs1_execi", 4'd7, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    cyc("subs1_aluwb", 4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    issue(20'h0A000, 4'b0000);
    fetch("beq1_fetch", 2'b10, 2'b01);
    decode("beq1_decode", 2'b10, 2'b01);
    cyc("beq1_branch", 4'd9, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00);

    // SUBS producing Z=0, then BEQ not taken when conditional execution exists
    issue(20'hE2500, 4'b0000);
    fetch("subs2_fetch", 2'b00, 2'b00);
    decode("subs2_decode", 2'b00, 2'b00);
    cyc("subs2_execi", 4'd7, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    cyc("subs2_aluwb", 4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    issue(20'h0A000, 4'b0000);
    fetch("beq2_fetch", 2'b10, 2'b01);
    decode("beq2_decode", 2'b10, 2'b01);
    cyc("beq2_branch", 4'd9, !COND, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00);

    // ADD with Rd=PC
    issue(20'hE281F, 4'b0000);
    fetch("addpc_fetch", 2'b00, 2'b00);
    decode("addpc_decode", 2'b00, 2'b00);
    cyc("addpc_execi", 4'd7, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("addpc_aluwb", 4'd8, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // cond=1111 never executes when conditional execution exists
    issue(20'hF2821, 4'b0000);
    fetch("nv_fetch", 2'b00, 2'b00);
    decode("nv_decode", 2'b00, 2'b00);
    cyc("nv_execi", 4'd7, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("nv_aluwb", 4'd8, 0, 0, !COND, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Undefined op=11: FETCH, DECODE, straight back to FETCH
    issue(20'hEC000, 4'b0000);
    fetch("undef_fetch", 2'b11, 2'b00);
    decode("undef_decode", 2'b11, 2'b00);

    // Set Z again, then reset in MEMWRITE must clear flags
    issue(20'hE2500, 4'b0100);
    fetch("subs3_fetch", 2'b00, 2'b00);
    decode("subs3_decode", 2'b00, 2'b00);
    cyc("subs3_execi", 4'd7, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    cyc("subs3_aluwb", 4'd8, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    issue(20'hE5803, 4'b0000);
    fetch("str2_fetch", 2'b01, 2'b10);
    decode("str2_decode", 2'b01, 2'b10);
    cyc("str2_memadr", 4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00);
    rst = 1'b0;
    cyc("str2_rst", 4'd5, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00);
    rst = 1'b1;
    issue(20'h0A000, 4'b0000);
    fetch("beq3_fetch", 2'b10, 2'b01);
    decode("beq3_decode", 2'b10, 2'b01);
    cyc("beq3_branch", 4'd9, !COND, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
